int_ctrl: RTL and testbench

Three-source vectored interrupt controller for the single-cycle RISC-V core; it is the responder side of the core's interrupt interface. It detects rising edges on three external request lines and latches them as pending. It raises an interrupt request with a vector address, which the core acknowledges, and retires in-service levels on `uret`. It also holds the per-level return PC that the core reloads on `uret`, and supports priority nesting up to three levels.

---
 rtl/int_ctrl.sv | 133 +++++++++++++
 tb/tb_int_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: three-source vectored interrupt controller (responder side of the
// core's interrupt interface).
//
// Rising edges on irq_in are synchronized and latched as pending. The highest
// pending source is requested when it outranks the highest in-service level.
// The core acknowledges the request with int_ack and supplies the return PC.
// uret retires the current in-service level. Up to three levels can nest.
//
// Ports:
//   clk         in   system clock, rising-edge
//   rst         in   asynchronous active-high reset
//   irq_in[2:0] in   raw asynchronous request lines, bit n = source n
//   ie          in   global interrupt enable (gates the request only)
//   int_ack     in   one-cycle pulse, core takes the current request
//   ack_pc      in   return PC saved for the acknowledged level
//   uret        in   one-cycle pulse, core returns from the current level
//   int_req     out  interrupt request (combinational from registered state)
//   int_vec     out  entry address of the requested source, 0 when idle
//   ret_pc      out  saved PC of the current in-service level, 0 when none
//   pending     out  pending bits
//   in_service  out  in-service bits
//
// Handshake: int_req is a level. An int_ack that arrives while int_req is low
// is ignored. An int_ack that arrives while int_req is high consumes the
// request that was visible before that clock edge.
module int_ctrl #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] VEC0 = 32'h0000_0100,
    parameter logic [WIDTH-1:0] VEC1 = 32'h0000_0200,
    parameter logic [WIDTH-1:0] VEC2 = 32'h0000_0300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       irq_in,
    input  logic             ie,
    input  logic             int_ack,
    input  logic [WIDTH-1:0] ack_pc,
    input  logic             uret,
    output logic             int_req,
    output logic [WIDTH-1:0] int_vec,
    output logic [WIDTH-1:0] ret_pc,
    output logic [2:0]       pending,
    output logic [2:0]       in_service
);

    logic [2:0]       s1, s2, h;
    logic [2:0]       pend_q, insvc_q;
    logic [WIDTH-1:0] pc_slot [3];

    logic [2:0] irq_edge;
    logic       grant_vld, cur_vld;
    logic [1:0] grant_idx, cur_idx;
    logic       ack_fire;
    logic [2:0] ack_mask, uret_mask;

    assign irq_edge = s2 & ~h;

    // Priority encoders: the higher bit index means the higher priority.
    always_comb begin
        grant_vld = |pend_q;
        grant_idx = 2'd0;
        if (pend_q[2])      grant_idx = 2'd2;
        else if (pend_q[1]) grant_idx = 2'd1;

        cur_vld = |insvc_q;
        cur_idx = 2'd0;
        if (insvc_q[2])      cur_idx = 2'd2;
        else if (insvc_q[1]) cur_idx = 2'd1;
    end

    // The request is made only when the grant strictly outranks the current level.
    assign int_req  = ie & grant_vld & (~cur_vld | (grant_idx > cur_idx));
    assign ack_fire = int_ack & int_req;

    always_comb begin
        ack_mask  = 3'b000;
        uret_mask = 3'b000;
        if (ack_fire)
            ack_mask = 3'b001 << grant_idx;
        if (uret && cur_vld)
            uret_mask = 3'b001 << cur_idx;
    end

    always_comb begin
        int_vec = '0;
        if (int_req) begin
            case (grant_idx)
                2'd2:    int_vec = VEC2;
                2'd1:    int_vec = VEC1;
                default: int_vec = VEC0;
            endcase
        end
    end

    always_comb begin
        ret_pc = '0;
        if (cur_vld) begin
            case (cur_idx)
                2'd2:    ret_pc = pc_slot[2];
                2'd1:    ret_pc = pc_slot[1];
                default: ret_pc = pc_slot[0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 3'b000;
            s2      <= 3'b000;
            h       <= 3'b000;
            pend_q  <= 3'b000;
            insvc_q <= 3'b000;
            for (int i = 0; i < 3; i++)
                pc_slot[i] <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            h  <= s2;
            // A fresh edge wins over the ack clear, so an event is never lost.
            pend_q <= irq_edge | (pend_q & ~ack_mask);
            // The uret clear is applied before the ack set. The two masks never
            // overlap, because the grant strictly outranks the current level.
            insvc_q <= (insvc_q & ~uret_mask) | ack_mask;
            for (int i = 0; i < 3; i++)
                if (ack_mask[i])
                    pc_slot[i] <= ack_pc;
        end
    end

    assign pending    = pend_q;
    assign in_service = insvc_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        ie;
    logic        int_ack;
    logic [31:0] ack_pc;
    logic        uret;
    logic        int_req;
    logic [31:0] int_vec;
    logic [31:0] ret_pc;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int tests  = 0;
    int failed = 0;

    int_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .ie         (ie),
        .int_ack    (int_ack),
        .ack_pc     (ack_pc),
        .uret       (uret),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .ret_pc     (ret_pc),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Reference model. In-service levels are kept as a nesting stack of
    // (level, saved pc). Raw input samples are kept as a short history:
    // a sample that rises at edge t appears as pending at edge t+2.
    int          stk_lvl[$];
    logic [31:0] stk_pc[$];
    logic [2:0]  m_pend;
    logic [2:0]  hist[$];

    function automatic int m_grant();
        for (int i = 2; i >= 0; i--)
            if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic int m_cur();
        if (stk_lvl.size() == 0) return -1;
        return stk_lvl[stk_lvl.size()-1];
    endfunction

    function automatic logic m_req();
        return ie && (m_grant() >= 0) && (m_grant() > m_cur());
    endfunction

    function automatic logic [31:0] m_vec();
        if (!m_req()) return 32'h0;
        case (m_grant())
            2:       return 32'h300;
            1:       return 32'h200;
            default: return 32'h100;
        endcase
    endfunction

    function automatic logic [2:0] m_insvc();
        logic [2:0] v = 3'b000;
        foreach (stk_lvl[i]) v[stk_lvl[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] m_retpc();
        if (stk_pc.size() == 0) return 32'h0;
        return stk_pc[stk_pc.size()-1];
    endfunction

    task automatic m_reset();
        stk_lvl.delete();
        stk_pc.delete();
        hist.delete();
        m_pend = 3'b000;
        repeat (3) hist.push_back(3'b000);
    endtask

    // Advances the model across one rising edge, using the inputs in force
    // before that edge.
    task automatic m_edge();
        int         g, c;
        logic       r;
        logic [2:0] ev;
        g  = m_grant();
        c  = m_cur();
        r  = m_req();
        ev = hist[1] & ~hist[0];
        if (uret && stk_lvl.size() > 0) begin
            void'(stk_lvl.pop_back());
            void'(stk_pc.pop_back());
        end
        if (int_ack && r) begin
            stk_lvl.push_back(g);
            stk_pc.push_back(ack_pc);
            m_pend[g] = 1'b0;
        end
        m_pend = m_pend | ev;
        void'(hist.pop_front());
        hist.push_back(irq_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pending",    {29'b0, pending},    {29'b0, m_pend});
        chk("in_service", {29'b0, in_service}, {29'b0, m_insvc()});
        chk("int_req",    {31'b0, int_req},    {31'b0, m_req()});
        chk("int_vec",    int_vec,             m_vec());
        chk("ret_pc",     ret_pc,              m_retpc());
    endtask

    // One clock cycle: drive the inputs after a falling edge, cross the rising
    // edge, then compare at the next falling edge.
    task automatic step(input logic [2:0] irq, input logic ie_v, input logic ack,
                        input logic [31:0] pc, input logic ur);
        irq_in  = irq;
        ie      = ie_v;
        int_ack = ack;
        ack_pc  = pc;
        uret    = ur;
        @(posedge clk);
        m_edge();
        @(negedge clk);
        check_model();
    endtask

    int         rises;
    logic       prev_p0;
    logic [2:0] rirq;

    initial begin
        // Clock/reset block.
        rst = 1'b1; irq_in = 3'b000; ie = 1'b0; int_ack = 1'b0;
        ack_pc = 32'h0; uret = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_int_vec", int_vec, 32'h0);
        chk("rst_ret_pc",  ret_pc, 32'h0);
        chk("rst_pending", {29'b0, pending}, 32'h0);
        chk("rst_in_service", {29'b0, in_service}, 32'h0);
        rst = 1'b0;

        // Basic round trip.
        step(3'b010, 1, 0, 0, 0);
        chk("basic_lat1_pending", {29'b0, pending}, 32'h0);
        step(3'b010, 1, 0, 0, 0);
        chk("basic_lat2_req", {31'b0, int_req}, 32'h0);
        step(3'b010, 1, 0, 0, 0);
        chk("basic_pending", {29'b0, pending}, 32'h2);
        chk("basic_req", {31'b0, int_req}, 32'h1);
        chk("basic_vec", int_vec, 32'h200);
        step(3'b000, 1, 1, 32'h44, 0);
        chk("basic_ack_insvc", {29'b0, in_service}, 32'h2);
        chk("basic_ack_retpc", ret_pc, 32'h44);
        chk("basic_ack_req", {31'b0, int_req}, 32'h0);
        step(3'b000, 1, 0, 0, 1);
        chk("basic_uret_insvc", {29'b0, in_service}, 32'h0);
        chk("basic_uret_retpc", ret_pc, 32'h0);

        // Nesting.
        repeat (3) step(3'b001, 1, 0, 0, 0);
        step(3'b000, 1, 1, 32'h10, 0);
        repeat (3) step(3'b100, 1, 0, 0, 0);
        chk("nest_req", {31'b0, int_req}, 32'h1);
        chk("nest_vec", int_vec, 32'h300);
        step(3'b000, 1, 1, 32'h120, 0);
        chk("nest_insvc", {29'b0, in_service}, 32'h5);
        chk("nest_retpc", ret_pc, 32'h120);
        step(3'b000, 1, 0, 0, 1);
        chk("nest_uret1_retpc", ret_pc, 32'h10);
        step(3'b000, 1, 0, 0, 1);
        chk("nest_uret2_insvc", {29'b0, in_service}, 32'h0);

        // Blocked lower priority.
        repeat (3) step(3'b100, 1, 0, 0, 0);
        step(3'b000, 1, 1, 32'h300, 0);
        repeat (3) step(3'b010, 1, 0, 0, 0);
        chk("block_pending", {29'b0, pending}, 32'h2);
        chk("block_req", {31'b0, int_req}, 32'h0);
        step(3'b000, 1, 0, 0, 1);
        chk("block_uret_req", {31'b0, int_req}, 32'h1);
        chk("block_uret_vec", int_vec, 32'h200);
        step(3'b000, 1, 1, 32'h8, 0);
        step(3'b000, 1, 0, 0, 1);

        // Enable gating.
        repeat (3) step(3'b111, 0, 0, 0, 0);
        chk("gate_pending", {29'b0, pending}, 32'h7);
        chk("gate_req", {31'b0, int_req}, 32'h0);
        step(3'b000, 1, 0, 0, 0);
        chk("gate_vec", int_vec, 32'h300);
        repeat (3) begin
            step(3'b000, 1, 1, $urandom, 0);
            step(3'b000, 1, 0, 0, 1);
        end
        chk("gate_drain_pending", {29'b0, pending}, 32'h0);
        chk("gate_drain_insvc", {29'b0, in_service}, 32'h0);

        // Same-source edge on the ack cycle.
        repeat (2) step(3'b010, 1, 0, 0, 0);
        repeat (3) step(3'b000, 1, 0, 0, 0);
        step(3'b010, 1, 0, 0, 0);
        step(3'b010, 1, 0, 0, 0);
        step(3'b010, 1, 1, 32'h50, 0);
        chk("edge_ack_pending", {29'b0, pending}, 32'h2);
        chk("edge_ack_insvc", {29'b0, in_service}, 32'h2);
        step(3'b000, 1, 0, 0, 1);
        // uret with nothing in service.
        step(3'b000, 1, 0, 0, 1);
        chk("idle_uret_pending", {29'b0, pending}, 32'h2);
        chk("idle_uret_insvc", {29'b0, in_service}, 32'h0);
        // int_ack while int_req is low.
        step(3'b000, 0, 1, 32'h55, 0);
        chk("idle_ack_insvc", {29'b0, in_service}, 32'h0);
        chk("idle_ack_pending", {29'b0, pending}, 32'h2);
        chk("idle_ack_retpc", ret_pc, 32'h0);
        step(3'b000, 1, 1, 32'h66, 0);
        step(3'b000, 1, 0, 0, 1);

        // A held-high level produces exactly one pending event.
        rises   = 0;
        prev_p0 = pending[0];
        repeat (20) begin
            step(3'b001, 1, 0, 0, 0);
            if (pending[0] && !prev_p0) rises++;
            prev_p0 = pending[0];
        end
        chk("hold_rises", rises, 32'd1);
        step(3'b001, 1, 1, 32'h70, 0);
        repeat (3) step(3'b001, 1, 0, 0, 0);
        chk("hold_no_retrigger", {29'b0, pending}, 32'h0);
        step(3'b000, 1, 0, 0, 1);

        // Reset mid-operation.
        repeat (3) step(3'b001, 1, 0, 0, 0);
        step(3'b000, 1, 1, 32'h1, 0);
        repeat (3) step(3'b010, 1, 0, 0, 0);
        step(3'b000, 1, 1, 32'h2, 0);
        repeat (3) step(3'b100, 1, 0, 0, 0);
        chk("pre_rst_insvc", {29'b0, in_service}, 32'h3);
        chk("pre_rst_pending", {29'b0, pending}, 32'h4);
        irq_in = 3'b000;
        #2 rst = 1'b1;
        m_reset();
        #0.5;
        chk("mid_rst_req", {31'b0, int_req}, 32'h0);
        chk("mid_rst_vec", int_vec, 32'h0);
        chk("mid_rst_retpc", ret_pc, 32'h0);
        chk("mid_rst_pending", {29'b0, pending}, 32'h0);
        chk("mid_rst_insvc", {29'b0, in_service}, 32'h0);
        #0.5 rst = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model.
        rirq = 3'b000;
        repeat (400) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) rirq[b] = ~rirq[b];
            step(rirq, ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1),
                 $urandom, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
